// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller slice.
//   WordWidth     : instruction / address word width
//   PcStep        : PC increment per sequential fetch
//   fetch_state_e : fetch FSM state encoding
//   align_word()  : clears the byte-offset bits of an address
package fetch_controller_pkg;

    localparam int unsigned WordWidth = 32;
    localparam logic [WordWidth-1:0] PcStep = 32'd4;

    typedef enum logic [1:0] {
        StBoot     = 2'd0,
        StFetch    = 2'd1,
        StRedirect = 2'd2,
        StHalted   = 2'd3
    } fetch_state_e;

    function automatic logic [WordWidth-1:0] align_word(input logic [WordWidth-1:0] addr);
        return {addr[WordWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, instr} pairs for decode.
//   clk, rst      : clock, synchronous active-low reset
//   push/push_data: enqueue one entry (accepted when not full, or full with a pop)
//   pop           : dequeue head (ignored when empty)
//   flush         : discard all entries; dominates push
//   head_data     : head entry, zero when empty
//   empty, count  : occupancy status
// Depth must be a power of two (2 or 4) so pointers wrap naturally.
module fetch_buffer #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 64,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [Width-1:0] head_data,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign do_pop  = pop & ~empty;
    // A full buffer can still accept when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the PC, fetches from an external
// combinational instruction memory and queues {pc, instr} for decode.
//   clk, rst                     : clock, synchronous active-low reset
//   imem_addr / imem_instr       : fetch address out, instruction back (same cycle)
//   jump_valid / jump_target     : unconditional redirect (higher priority)
//   branch_taken / branch_target : taken-branch redirect
//   halt_req                     : stop fetching after the current cycle
//   out_valid/out_ready/out_instr/out_pc : decode handshake on buffer head
//   misalign_err                 : sticky, a redirect target had low bits set
//   halted                       : high while fetch is halted
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WordWidth-1:0] imem_instr,
    output logic [WordWidth-1:0] imem_addr,
    input  logic                 jump_valid,
    input  logic [WordWidth-1:0] jump_target,
    input  logic                 branch_taken,
    input  logic [WordWidth-1:0] branch_target,
    input  logic                 halt_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WordWidth-1:0] out_instr,
    output logic [WordWidth-1:0] out_pc,
    output logic                 misalign_err,
    output logic                 halted
);

    localparam int unsigned EntryW = 2 * WordWidth;
    localparam int unsigned CntW   = $clog2(BUF_DEPTH + 1);

    fetch_state_e         state_q, state_d;
    logic [WordWidth-1:0] pc_q, pc_d;
    logic                 misalign_q, misalign_d;
    logic                 halted_q, halted_d;

    logic                 redirect;
    logic [WordWidth-1:0] redirect_target;
    logic                 pop;
    logic                 fetch;
    logic                 buf_full;
    logic                 buf_empty;
    logic [CntW-1:0]      buf_count;
    logic [EntryW-1:0]    buf_head;

    always_comb begin
        // Redirects are ignored during the boot cycle.
        redirect        = (state_q != StBoot) & (jump_valid | branch_taken);
        redirect_target = jump_valid ? jump_target : branch_target;
        buf_full        = (buf_count == CntW'(BUF_DEPTH));
        pop             = ~buf_empty & out_ready;
        fetch           = (state_q == StFetch) & ~redirect & (~buf_full | pop);

        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;

        if (redirect) begin
            // Redirect beats halt_req and restarts REDIRECT if already there.
            state_d    = StRedirect;
            pc_d       = align_word(redirect_target);
            misalign_d = misalign_q | (|redirect_target[1:0]);
        end else begin
            unique case (state_q)
                StBoot:     state_d = StFetch;
                StFetch: begin
                    if (fetch) begin
                        pc_d = pc_q + PcStep;
                    end
                    if (halt_req) begin
                        state_d = StHalted;
                    end
                end
                StRedirect: state_d = StFetch;
                StHalted:   state_d = StHalted;
                default:    state_d = StBoot;
            endcase
        end

        halted_d = (state_d == StHalted);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
        end
    end

    fetch_buffer #(
        .Depth (BUF_DEPTH),
        .Width (EntryW)
    ) u_fetch_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_data ({pc_q, imem_instr}),
        .pop       (pop),
        .flush     (redirect),
        .head_data (buf_head),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign imem_addr    = pc_q;
    assign out_valid    = ~buf_empty;
    assign out_pc       = buf_head[EntryW-1:WordWidth];
    assign out_instr    = buf_head[WordWidth-1:0];
    assign misalign_err = misalign_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a scoreboard of expected
// {pc, instr} pairs consumed by a monitor on every decode handshake.
module tb_fetch_controller;

    localparam logic [31:0] ResetVector = 32'h0000_0000;
    localparam logic [31:0] InstrKey    = 32'hC0DE_5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        halt_req = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Instruction memory: word derived from its address.
    assign imem_instr = imem_addr ^ InstrKey;

    fetch_controller #(
        .RESET_VECTOR (ResetVector),
        .BUF_DEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_instr    (imem_instr),
        .imem_addr     (imem_addr),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .misalign_err  (misalign_err),
        .halted        (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [31:0] pc);
        exp_q.push_back(pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Holds reset across two edges, checking state after the first one.
    task automatic reset_dut(input string name);
        tick();
        rst          = 1'b0;
        jump_valid   = 1'b0;
        branch_taken = 1'b0;
        halt_req     = 1'b0;
        tick();
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_addr"}, imem_addr, ResetVector);
        check({name, "_pc"}, out_pc, 32'd0);
        check({name, "_instr"}, out_instr, 32'd0);
        check({name, "_halted"}, 32'(halted), 32'd0);
        check({name, "_misalign"}, 32'(misalign_err), 32'd0);
        tick();
        rst = 1'b1;
    endtask

    // Monitor: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc 0x%08h, expected no output", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", out_pc, e);
                check("sb_instr", out_instr, e ^ InstrKey);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset release, streaming with decode always ready.
        reset_dut("rst_init");
        out_ready = 1'b1;
        sb_push(32'h0);
        sb_push(32'h4);
        tick();
        @(negedge clk);
        check("boot_valid", 32'(out_valid), 32'd0);
        check("boot_addr", imem_addr, ResetVector);
        tick();
        @(negedge clk);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'h0);
        tick();
        @(negedge clk);
        check("second_pc", out_pc, 32'h4);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("third_pc", out_pc, 32'h8);
        tick();
        tick();
        @(negedge clk);
        check("a_stall_addr", imem_addr, 32'h10);
        check("a_stall_head", out_pc, 32'h8);
        tick();
        sb_drained("a_drained");
        // Reset with a full buffer discards everything.
        reset_dut("rst_full");

        // Backpressure from empty: fill, stall, then release.
        out_ready = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("b_full_addr", imem_addr, 32'h8);
        check("b_full_head", out_pc, 32'h0);
        tick();
        out_ready = 1'b1;
        sb_push(32'h0);
        sb_push(32'h4);
        sb_push(32'h8);
        sb_push(32'hC);
        repeat (4) tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("b_head_after", out_pc, 32'h10);
        check("b_addr_after", imem_addr, 32'h18);

        // Jump and branch together: jump wins, flush, one bubble.
        tick();
        sb_drained("b_drained");
        jump_valid    = 1'b1;
        jump_target   = 32'h100;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        tick();
        jump_valid   = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        check("c_flush_valid", 32'(out_valid), 32'd0);
        check("c_redirect_addr", imem_addr, 32'h100);
        check("c_misalign_clear", 32'(misalign_err), 32'd0);
        tick();
        @(negedge clk);
        check("c_bubble_valid", 32'(out_valid), 32'd0);
        tick();
        out_ready = 1'b1;
        sb_push(32'h100);
        sb_push(32'h104);
        sb_push(32'h108);
        @(negedge clk);
        check("c_target_pc", out_pc, 32'h100);
        tick();
        // Misaligned branch while the head 0x108 is being accepted.
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h203;
        @(negedge clk);
        check("d_pop_in_redirect", out_pc, 32'h108);
        tick();
        branch_taken = 1'b0;
        sb_push(32'h200);
        @(negedge clk);
        check("d_misalign_set", 32'(misalign_err), 32'd1);
        check("d_flush_valid", 32'(out_valid), 32'd0);
        check("d_aligned_addr", imem_addr, 32'h200);
        tick();
        tick();
        @(negedge clk);
        check("d_target_pc", out_pc, 32'h200);
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        // Halt with two entries buffered.
        halt_req = 1'b1;
        @(negedge clk);
        check("e_not_halted", 32'(halted), 32'd0);
        tick();
        halt_req = 1'b0;
        @(negedge clk);
        check("e_halted", 32'(halted), 32'd1);
        check("e_halt_addr", imem_addr, 32'h20C);
        check("e_halt_head", out_pc, 32'h204);
        tick();
        out_ready = 1'b1;
        sb_push(32'h204);
        sb_push(32'h208);
        tick();
        tick();
        @(negedge clk);
        check("e_drained_valid", 32'(out_valid), 32'd0);
        check("e_still_halted", 32'(halted), 32'd1);
        tick();
        @(negedge clk);
        check("e_pc_held", imem_addr, 32'h20C);
        check("e_no_fetch", 32'(out_valid), 32'd0);

        // Redirect out of HALTED with a simultaneous halt_req.
        tick();
        sb_drained("e_drained");
        jump_valid  = 1'b1;
        jump_target = 32'h40;
        halt_req    = 1'b1;
        tick();
        jump_valid = 1'b0;
        halt_req   = 1'b0;
        @(negedge clk);
        check("f_unhalted", 32'(halted), 32'd0);
        check("f_addr", imem_addr, 32'h40);
        check("f_misalign_sticky", 32'(misalign_err), 32'd1);
        tick();
        tick();
        sb_push(32'h40);
        sb_push(32'h44);
        @(negedge clk);
        check("f_resume_pc", out_pc, 32'h40);
        check("f_halt_ignored", 32'(halted), 32'd0);
        tick();
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("f_head", out_pc, 32'h48);
        check("f_fetch_addr", imem_addr, 32'h4C);

        // PC wrap from the top of the address space.
        tick();
        sb_drained("f_drained");
        jump_valid  = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        jump_valid = 1'b0;
        @(negedge clk);
        check("g_top_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        out_ready = 1'b1;
        sb_push(32'hFFFF_FFFC);
        sb_push(32'h0);
        @(negedge clk);
        check("g_top_pc", out_pc, 32'hFFFF_FFFC);
        check("g_wrap_addr", imem_addr, 32'h0);
        tick();
        @(negedge clk);
        check("g_wrap_pc", out_pc, 32'h0);
        tick();
        out_ready = 1'b0;
        tick();
        sb_drained("g_drained");
        reset_dut("rst_final");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (rst==0 at a rising edge resets).
REQ-005 imem_instr  input  32  instruction returned combinationally by instruction memory for imem_addr.
REQ-006 imem_addr  output  32  fetch address driven to instruction memory (current PC).
REQ-007 jump_valid  input  1  unconditional redirect request.
REQ-008 jump_target  input  32  jump destination.
REQ-009 branch_taken  input  1  taken-branch redirect request.
REQ-010 branch_target  input  32  branch destination.
REQ-011 halt_req  input  1  stop fetching after current cycle.
REQ-012 out_valid  output  1  buffer head holds a valid instruction for decode.
REQ-013 out_ready  input  1  decode accepts head this cycle.
REQ-014 out_instr  output  32  head instruction.
REQ-015 out_pc  output  32  address of head instruction.
REQ-016 misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.
REQ-017 halted  output  1  high while in HALTED state.

Function
REQ-018 FSM states: BOOT, FETCH, REDIRECT, HALTED; one-hot or binary encoding is implementer's choice.
REQ-019 BOOT lasts exactly one cycle after reset release, no fetch, then -> FETCH.
REQ-020 In FETCH, a fetch occurs when the buffer has a free slot, or is full with a pop (out_valid & out_ready) in the same cycle.
REQ-021 A fetch pushes {imem_addr, imem_instr} into the buffer and advances PC by 4 (mod 2^32, wrap to 0 silently).
REQ-022 In FETCH with no free slot and no pop, PC and buffer hold (stall).
REQ-023 out_valid = buffer non-empty; out_instr/out_pc = head entry; pop on out_valid & out_ready.
REQ-024 Redirect = jump_valid | branch_taken, honoured in any state except BOOT; jump_valid has priority over branch_taken.
REQ-025 On redirect: PC <= target with bits [1:0] forced to 0; buffer flushed at the same edge; no push that cycle; state -> REDIRECT.
REQ-026 A pop handshake in the redirect cycle completes normally (entry counts as consumed), then the flush applies.
REQ-027 REDIRECT lasts one cycle (bubble, no fetch), then -> FETCH; a further redirect in REDIRECT restarts it with the new target.
REQ-028 Target with bits [1:0] != 0 sets misalign_err; cleared only by reset.
REQ-029 halt_req in FETCH (no redirect) -> HALTED at next edge; fetch in that cycle still occurs per REQ-020.
REQ-030 In HALTED: no fetches, PC holds, buffer drains normally via pops; redirect leaves HALTED via REQ-025.
REQ-031 Redirect and halt_req in the same cycle: redirect wins, halt_req ignored.
REQ-032 Buffer never overflows or underflows; push and pop in the same cycle leave the count unchanged.

Reset
REQ-033 While rst==0 at an edge: PC = RESET_VECTOR, state = BOOT, buffer empty, misalign_err = 0.
REQ-034 Reset values: imem_addr = RESET_VECTOR, out_valid = 0, out_instr = 0, out_pc = 0, halted = 0.
REQ-035 Reset mid-operation (any state, any occupancy) discards all state in one edge; no partial pop is reported.

Structure
REQ-036 Shared package holds FSM state encoding, PC_STEP = 4 and the 32-bit word width constant.
REQ-037 Buffer is one sub-module, fetch_buffer: synchronous FIFO with push, pop, flush, count; flush dominates push.
REQ-038 Instruction memory stays external; fetch_controller owns the PC register.

Verification
REQ-039 Reset release, out_ready=1, imem returns addr-derived words -> out_pc 0x0, 0x4, 0x8 on consecutive cycles starting 2 cycles after release.
REQ-040 out_ready=0 for 5 cycles from empty -> buffer fills to BUF_DEPTH, PC stops at 0x8 (depth 2), no entry lost or duplicated on release.
REQ-041 jump_valid=1, jump_target=0x100 with branch_taken=1, branch_target=0x200 -> buffer flushed, one bubble, next out_pc=0x100.
REQ-042 branch_target=0x203 -> misalign_err=1 and stays set, next out_pc=0x200.
REQ-043 halt_req with 2 entries buffered -> halted=1, both entries drain, no further fetch; redirect to 0x40 -> resumes at 0x40.
REQ-044 PC=0xFFFF_FFFC fetch -> next fetch address 0x0000_0000; rst=0 while buffer full -> out_valid=0 and imem_addr=RESET_VECTOR next cycle.
